fifo_stream_drainer: RTL and testbench
======================================

# fifo_stream_drainer

Read-side companion to the 8-deep, 32-bit FIFO buffer register. It pops words from the FIFO through its RD/EMPTY/dataOut port and re-presents them downstream on a valid/ready stream with full throughput. It hides the FIFO's one-cycle registered read latency behind a 2-entry skid buffer and counts delivered words.

## Interface
- DATA_W, 32: word width; matches FIFO dataIn/dataOut.
- CNT_W, 16: width of WordCount.
- Clk  in  1  rising-edge clock, shared with the FIFO.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  drain enable; low stops new FIFO reads only.
- FifoEmpty  in  1  FIFO EMPTY flag.
- FifoRd  out  1  FIFO RD strobe; integrator ties FIFO EN high.
- FifoData  in  DATA_W  FIFO dataOut.
- OutData  out  DATA_W  head word of the skid buffer.
- OutValid  out  1  OutData holds a word.
- OutReady  in  1  downstream accepts; a transfer occurs on an edge where OutValid && OutReady.
- WordCount  out  CNT_W  number of transfers since reset, modulo 2^CNT_W.
- Busy  out  1  high when the state is not IDLE.

## Operation
- The FIFO samples RD at edge N. FifoData is valid after edge N. The drainer captures it at edge N+1.
- Registered state:
  - occ: 0..2 words held in the buffer.
  - inflight: 1 bit, set when a read was issued last cycle.
  - state
  - WordCount
- pop = OutValid && OutReady.
- FifoRd = En && !FifoEmpty && (occ + inflight - pop) < 2. This is combinational from registered state, FifoEmpty and OutReady. It never reads while FifoEmpty is high.
- inflight_next = FifoRd. When inflight is high, FifoData is written into the buffer tail at the next edge.
- A capture and a pop in the same cycle are both performed. occ is unchanged and the order is preserved.
- OutData/OutValid come from buffer entry 0. When entry 0 is popped, entry 1 shifts down.
- WordCount increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- FSM:
  - IDLE: no work. Go to FETCH when FifoRd asserts.
  - FETCH: reading or draining. Go to STALL when occ + inflight == 2 and !OutReady. Go to IDLE when occ == 0, inflight == 0 and FifoRd is low.
  - STALL: buffer full, downstream blocked, FifoRd = 0. Go to FETCH on pop.
- En deasserted mid-operation:
  - No new reads are issued.
  - An in-flight word is still captured.
  - Buffered words still drain.
  - The FSM then returns to IDLE.
- FIFO goes empty mid-burst: FifoRd drops and the buffer drains. Reads resume the cycle after FifoEmpty falls.

## Timing
- Reset (Rst low, asynchronous) clears:
  - OutValid = 0, OutData = 0, FifoRd = 0 (occ = 0, inflight = 0), WordCount = 0, Busy = 0.
  - State = IDLE.
  - Buffer contents are discarded.
- Reset mid-operation: an in-flight word is dropped. The FIFO is expected to be reset together with the drainer.
- Latency: 2 cycles from FifoRd assertion (edge N) to OutValid high (after edge N+1).
- Throughput: 1 word/cycle sustained while FifoEmpty is low and OutReady is held high.
- OutData must hold stable while OutValid && !OutReady.

## Configuration
- Macro FIFO_DRAIN_PARITY_EN.
- Defined:
  - Adds output OutParity (1 bit), the even parity (XOR-reduce) of OutData.
  - Parity is computed at capture and stored alongside each buffer entry, so it is registered with the word.
  - Reset value is 0.
- Undefined: the port and its storage are absent. All other behaviour is identical.

## Structure
- Package fifo_drain_pkg holds:
  - the state typedef (IDLE, FETCH, STALL)
  - SKID_DEPTH = 2
  - the default widths
- Sub-module drain_skid_buf is the 2-entry shift buffer. It provides push, pop, occ, head data and, under the macro, the parity bit.
- The top level holds the FSM, FifoRd logic, inflight and WordCount.

## Test plan
- Reset: hold Rst low with the FIFO containing 3 words -> FifoRd = 0, OutValid = 0, WordCount = 0 until release.
- Burst: write 0x11..0x18 (8 words), OutReady = 1 -> OutData 0x11..0x18 on 8 consecutive cycles, first word 2 cycles after the first FifoRd, WordCount = 8.
- Back-pressure: 4 words, OutReady low 5 cycles after the first OutValid -> at most 2 reads issued, state STALL, no word lost or duplicated on release.
- En toggle: deassert En one cycle after FifoRd -> the in-flight word is still delivered, no further reads, Busy falls once the buffer is empty.
- Wrap: CNT_W = 4, stream 17 words -> WordCount reads 1.
- Parity (macro defined): word 0x00000007 -> OutParity = 1; word 0x00000003 -> OutParity = 0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared widths, skid depth and FSM state encoding for the FIFO stream drainer.
// No ports. The optional FIFO_DRAIN_PARITY_EN build adds parity storage in the users of this package.
package fifo_drain_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int SKID_DEPTH = 2;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t STALL = 2'd2;
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry in-order shift buffer that absorbs the FIFO's registered read latency.
// Ports: clk_i, rst_ni (async, active-low); push_i/push_data_i write the tail; pop_i removes the head;
//        occ_o is the entry count (0..2); head_o is entry 0.
// Macro FIFO_DRAIN_PARITY_EN adds head_par_o, the parity of entry 0, computed and stored at push time.
module drain_skid_buf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_o
`ifdef FIFO_DRAIN_PARITY_EN
    , output logic            head_par_o
`endif
);
    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic [DATA_W-1:0] mem_d [SKID_DEPTH];
    logic [1:0]        occ_q, occ_d, base;
`ifdef FIFO_DRAIN_PARITY_EN
    logic par_q [SKID_DEPTH];
    logic par_d [SKID_DEPTH];
`endif

    // Shift on pop first, then append at the first free slot, so a same-cycle
    // pop and push keep the word order and leave occ unchanged.
    always_comb begin
        base     = occ_q - {1'b0, pop_i};
        mem_d[0] = pop_i ? mem_q[1] : mem_q[0];
        mem_d[1] = mem_q[1];
        if (push_i) mem_d[base[0]] = push_data_i;
        occ_d    = base + {1'b0, push_i};
    end

`ifdef FIFO_DRAIN_PARITY_EN
    always_comb begin
        par_d[0] = pop_i ? par_q[1] : par_q[0];
        par_d[1] = par_q[1];
        if (push_i) par_d[base[0]] = ^push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) par_q <= '{default: 1'b0};
        else         par_q <= par_d;
    end

    assign head_par_o = par_q[0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= 2'd0;
            mem_q <= '{default: '0};
        end else begin
            occ_q <= occ_d;
            mem_q <= mem_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[0];
endmodule

// File: rtl/fifo_stream_drainer.sv
// fifo_stream_drainer: pops an 8-deep FIFO (RD/EMPTY/dataOut) and re-presents words on a valid/ready stream.
// Ports: clk_i, rst_ni (async, active-low); en_i drain enable; fifo_empty_i/fifo_rd_o/fifo_data_i FIFO side;
//        out_data_o/out_valid_o/out_ready_i stream side; word_count_o transfers mod 2^CNT_W; busy_o state != IDLE.
// Macro FIFO_DRAIN_PARITY_EN adds out_parity_o, the registered XOR-reduce of out_data_o.
module fifo_stream_drainer
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  word_count_o,
    output logic              busy_o
`ifdef FIFO_DRAIN_PARITY_EN
    , output logic            out_parity_o
`endif
);
    logic [1:0]       occ, level;
    logic             inflight_q, pop;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    assign out_valid_o = occ != 2'd0;
    assign pop         = out_valid_o && out_ready_i;
    // Words that will sit in the buffer after this edge; a new read only fits if fewer than two.
    assign level       = occ + {1'b0, inflight_q} - {1'b0, pop};
    // Gated by reset so no read strobe reaches the FIFO while the buffer is being cleared.
    assign fifo_rd_o   = rst_ni && en_i && !fifo_empty_i && level < 2'd2;

    drain_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (out_data_o)
`ifdef FIFO_DRAIN_PARITY_EN
        , .head_par_o(out_parity_o)
`endif
    );

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = fifo_rd_o ? FETCH : IDLE;
            FETCH:   state_d = (occ + {1'b0, inflight_q} == 2'd2 && !out_ready_i) ? STALL :
                               (occ == 2'd0 && !inflight_q && !fifo_rd_o) ? IDLE : FETCH;
            STALL:   state_d = pop ? FETCH : STALL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_o;
            cnt_q      <= cnt_q + CNT_W'(pop);
        end
    end

    assign word_count_o = cnt_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_fifo_stream_drainer.sv
// tb_fifo_stream_drainer: randomized and directed bench with a queue-based reference model and FIFO model.
module tb_fifo_stream_drainer;
    import fifo_drain_pkg::*;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, ready = 1'b0;
    logic         fifo_empty = 1'b1, fifo_clr = 1'b0, wr = 1'b0;
    logic [W-1:0] fifo_data = '0, wdata = '0;
    logic         rd, rd_w, valid, valid_w, busy, busy_w, rd_s = 1'b0;
    logic [W-1:0] odata, odata_w;
    logic [15:0]  cnt;
    logic [3:0]   cnt_w;
`ifdef FIFO_DRAIN_PARITY_EN
    logic         par, par_w;
`endif

    int checks = 0, fails = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_seq[$];
    logic [W-1:0] mb[$];
    logic         m_inf = 1'b0, m_busy = 1'b0;
    int           m_cnt = 0;

    always #5 clk = ~clk;

    fifo_stream_drainer dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(fifo_empty), .fifo_rd_o(rd),
        .fifo_data_i(fifo_data), .out_data_o(odata), .out_valid_o(valid), .out_ready_i(ready),
        .word_count_o(cnt), .busy_o(busy)
`ifdef FIFO_DRAIN_PARITY_EN
        , .out_parity_o(par)
`endif
    );

    fifo_stream_drainer #(.CNT_W(4)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(fifo_empty), .fifo_rd_o(rd_w),
        .fifo_data_i(fifo_data), .out_data_o(odata_w), .out_valid_o(valid_w), .out_ready_i(ready),
        .word_count_o(cnt_w), .busy_o(busy_w)
`ifdef FIFO_DRAIN_PARITY_EN
        , .out_parity_o(par_w)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model: registered read, write port, depth 8.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
            exp_seq.delete();
        end else begin
            if (rd_s && fq.size() > 0) fifo_data <= fq.pop_front();
            if (wr && fq.size() < 8) begin
                fq.push_back(wdata);
                exp_seq.push_back(wdata);
            end
        end
        fifo_empty <= fq.size() == 0;
    end

    // Reference model and per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic m_valid, m_pop, m_rd, m_busy_n;
        rd_s = rd;
        if (!rst_n) begin
            chk("rst_rd", rd, 0);
            chk("rst_valid", valid, 0);
            chk("rst_data", odata, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_busy", busy, 0);
`ifdef FIFO_DRAIN_PARITY_EN
            chk("rst_par", par, 0);
`endif
            mb.delete();
            m_inf = 1'b0;
            m_busy = 1'b0;
            m_cnt = 0;
        end else begin
            m_valid = mb.size() > 0;
            m_pop = m_valid && ready;
            m_rd = en && !fifo_empty && (mb.size() + int'(m_inf) - int'(m_pop)) < 2;
            chk("rd", rd, m_rd);
            chk("rd_w", rd_w, m_rd);
            chk("valid", valid, m_valid);
            chk("valid_w", valid_w, m_valid);
            chk("busy", busy, m_busy);
            chk("busy_w", busy_w, m_busy);
            chk("count", cnt, 64'(m_cnt % 65536));
            chk("count_w", cnt_w, 64'(m_cnt % 16));
            if (m_valid) begin
                chk("data", odata, mb[0]);
                chk("data_w", odata_w, mb[0]);
`ifdef FIFO_DRAIN_PARITY_EN
                chk("parity", par, ^mb[0]);
                chk("parity_w", par_w, ^mb[0]);
`endif
            end
            if (valid && ready) begin
                if (exp_seq.size() == 0) chk("sb_extra_word", 1, 0);
                else chk("sb_order", odata, exp_seq.pop_front());
            end
            m_busy_n = m_rd || (m_busy && (mb.size() != 0 || m_inf));
            if (m_pop) begin
                void'(mb.pop_front());
                m_cnt++;
            end
            if (m_inf) mb.push_back(fifo_data);
            m_inf = m_rd;
            m_busy = m_busy_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] v);
        for (int n = 0; n < 50 && fq.size() >= 8; n++) step();
        wr = 1'b1;
        wdata = v;
        step();
        wr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        for (n = 0; n < 300; n++) begin
            if (fq.size() == 0 && !busy && !valid) break;
            step();
        end
        chk(nm, n < 300, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        int fr, fv, lv, reads, pops;
        logic [W-1:0] got[$];
        logic seen;
        step();
        // Reset held with 3 words in the FIFO and drain enabled.
        en = 1'b1;
        put(32'hA1); put(32'hA2); put(32'hA3);
        repeat (3) step();
        chk("rst_hold_rd", rd, 0);
        chk("rst_hold_valid", valid, 0);
        chk("rst_hold_cnt", cnt, 0);
        en = 1'b0;
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        rst_n = 1'b1;
        step();

        // Burst of 8 words at full throughput.
        for (int i = 0; i < 8; i++) put(32'h11 + i);
        ready = 1'b1;
        en = 1'b1;
        fr = -1; fv = -1; lv = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rd && fr < 0) fr = k;
            if (valid && ready) begin
                got.push_back(odata);
                if (fv < 0) fv = k;
                lv = k;
            end
        end
        step();
        chk("burst_latency", 64'(fv - fr), 2);
        chk("burst_consecutive", 64'(lv - fv), 7);
        chk("burst_words", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("burst_data", got[i], 32'h11 + i);
        wait_idle("burst_idle");
        chk("burst_count", cnt, 8);

        // Nine more words: 17 total wraps the 4-bit counter to 1.
        for (int i = 0; i < 9; i++) put(32'h19 + i);
        wait_idle("wrap_idle");
        chk("wrap_count16", cnt, 17);
        chk("wrap_count4", cnt_w, 1);

        // Back-pressure: downstream blocked from the start.
        en = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h31 + i);
        en = 1'b1;
        reads = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rd) reads++;
        end
        step();
        chk("bp_reads", reads, 2);
        chk("bp_state", dut.state_q, STALL);
        chk("bp_busy", busy, 1);
        ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_count", cnt, 21);

        // En dropped one cycle after the first read.
        en = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h41 + i);
        en = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = rd;
        end
        chk("entog_rd_seen", seen, 1);
        @(posedge clk);
        #1 en = 1'b0;
        reads = 0;
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd) reads++;
            if (valid && ready) pops++;
        end
        step();
        chk("entog_reads", reads, 0);
        chk("entog_pops", pops, 1);
        chk("entog_busy", busy, 0);
        chk("entog_left", fq.size(), 3);
        en = 1'b1;
        wait_idle("entog_idle");
        chk("entog_count", cnt, 25);

`ifdef FIFO_DRAIN_PARITY_EN
        ready = 1'b0;
        put(32'h7);
        put(32'h3);
        repeat (6) step();
        chk("par_head7", odata, 32'h7);
        chk("par_7", par, 1);
        ready = 1'b1;
        step();
        chk("par_head3", odata, 32'h3);
        chk("par_3", par, 0);
        wait_idle("par_idle");
`endif

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            en = $urandom_range(0, 9) < 8;
            ready = $urandom_range(0, 9) < 7;
            wr = fq.size() < 8 && $urandom_range(0, 1) == 1;
            wdata = $urandom;
            step();
        end
        wr = 1'b0;
        en = 1'b1;
        ready = 1'b1;
        wait_idle("rand_idle");

        // Asynchronous reset mid-operation drops buffered and in-flight words.
        en = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h51 + i);
        en = 1'b1;
        repeat (2) step();
        #2 rst_n = 1'b0;
        fifo_clr = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_rd", rd, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_busy", busy, 0);
        step();
        fifo_clr = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
